// File: rtl/axi4_uart_rx_bridge.sv
// ---------------------------------------------------------------------------
// axi4_uart_rx_bridge
//
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// small RX FIFO. The FIFO is exposed to an AXI4 read-only master through two
// registers:
//   BASE_ADDR     RXDATA : {23'b0, valid, byte}; a read pops the head byte
//   BASE_ADDR + 4 STATUS : {23'b0, parity_err, count[3:0], frame_err,
//                           overrun, full, not_empty}; a read clears the
//                           sticky error flags
// Any other address answers SLVERR with zero data.
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, plus a sticky PARITY_ERR flag at STATUS[8].
//
// Ports:
//   clk          system clock (single domain)
//   rst_n        synchronous active-low reset
//   uart_rx      asynchronous serial input, idle high
//   axi_ar*      AXI4 read address channel (arvalid/araddr/arid in, arready out)
//   axi_r*       AXI4 read data channel (rvalid/rdata/rresp/rlast/rid out,
//                rready in); one transaction outstanding at a time
//   rx_irq       FIFO not empty
//   rx_active    receiver busy with a frame (debug LED)
// ---------------------------------------------------------------------------
module axi4_uart_rx_bridge #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic        axi_arvalid,
    input  logic [31:0] axi_araddr,
    input  logic [3:0]  axi_arid,
    output logic        axi_arready,
    output logic        axi_rvalid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic [3:0]  axi_rid,
    input  logic        axi_rready,
    output logic        rx_irq,
    output logic        rx_active
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronizer. sync_valid_reg marks when rx_sync_reg carries a
    // real line sample rather than its reset value, so a line held low
    // through reset is not mistaken for a start bit.
    // ------------------------------------------------------------------
    logic       rx_meta_reg;
    logic       rx_sync_reg;
    logic [1:0] sync_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            sync_valid_reg <= 2'b00;
        end else begin
            rx_meta_reg    <= uart_rx;
            rx_sync_reg    <= rx_meta_reg;
            sync_valid_reg <= {sync_valid_reg[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        armed_reg;
    logic        push_req;
    logic        frame_err_evt;
`ifdef UART_RX_PARITY_EN
    logic        parity_bad_reg, parity_bad_next;
    logic        parity_err_evt;
`endif

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        push_req      = 1'b0;
        frame_err_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
        parity_err_evt  = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (armed_reg && !rx_sync_reg) begin
                    state_next   = S_START;
                    bit_cnt_next = HALF_LOAD;
                end
            end
            S_START: begin
                if (bit_cnt_reg == 16'd0) begin
                    // Mid start bit: still low means a real frame.
                    if (!rx_sync_reg) begin
                        state_next   = S_DATA;
                        bit_cnt_next = FULL_LOAD;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_cnt_reg == 16'd0) begin
                    shift_next   = {rx_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = FULL_LOAD;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt_reg == 16'd0) begin
                    // Even parity: the parity bit equals the XOR of the data.
                    parity_bad_next = rx_sync_reg ^ (^shift_reg);
                    parity_err_evt  = rx_sync_reg ^ (^shift_reg);
                    bit_cnt_next    = FULL_LOAD;
                    state_next      = S_STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_cnt_reg == 16'd0) begin
                    state_next = S_IDLE;
                    if (rx_sync_reg) begin
`ifdef UART_RX_PARITY_EN
                        push_req = !parity_bad_reg;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        frame_err_evt = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            armed_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
`endif
            // A new frame needs the line to be seen high while idle first,
            // so a low line after reset or after a framing error is ignored.
            if (state_reg == S_IDLE && state_next == S_START) begin
                armed_reg <= 1'b0;
            end else if (state_reg == S_IDLE && sync_valid_reg[1] && rx_sync_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rx_active = (state_reg != S_IDLE);

    // ------------------------------------------------------------------
    // RX FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             overrun_reg, frame_err_reg;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_reg;
`endif

    logic fifo_empty, fifo_full;
    logic ar_hs, sel_data, sel_status;
    logic pop, wr_en, overrun_evt, flag_clr;

    assign fifo_empty = (count_reg == 5'd0);
    assign fifo_full  = (count_reg == DEPTH_CNT);

    assign ar_hs      = axi_arvalid && !axi_rvalid;
    assign sel_data   = (axi_araddr == BASE_ADDR);
    assign sel_status = (axi_araddr == (BASE_ADDR + 32'd4));
    assign pop        = ar_hs && sel_data && !fifo_empty;
    // A push into a full FIFO still lands if a pop frees a slot this cycle.
    assign wr_en       = push_req && (!fifo_full || pop);
    assign overrun_evt = push_req && fifo_full && !pop;
    assign flag_clr    = ar_hs && sel_status;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= 5'd0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + {4'd0, wr_en} - {4'd0, pop};
            // An error arriving in the clearing cycle keeps its flag set.
            overrun_reg   <= overrun_evt   || (overrun_reg   && !flag_clr);
            frame_err_reg <= frame_err_evt || (frame_err_reg && !flag_clr);
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_err_evt || (parity_err_reg && !flag_clr);
`endif
        end
    end

    assign rx_irq = !fifo_empty;

    // ------------------------------------------------------------------
    // AXI read responder
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rdata_next;
    logic [1:0]  rresp_next;

    always_comb begin
        status_word      = 32'd0;
        status_word[0]   = !fifo_empty;
        status_word[1]   = fifo_full;
        status_word[2]   = overrun_reg;
        status_word[3]   = frame_err_reg;
        status_word[7:4] = count_reg[3:0];
`ifdef UART_RX_PARITY_EN
        status_word[8]   = parity_err_reg;
`endif
    end

    always_comb begin
        rdata_next = 32'd0;
        rresp_next = 2'b00;
        if (sel_data) begin
            if (!fifo_empty) begin
                rdata_next = {23'd0, 1'b1, fifo_mem[rd_ptr_reg]};
            end
        end else if (sel_status) begin
            rdata_next = status_word;
        end else begin
            rresp_next = 2'b10;
        end
    end

    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic [3:0]  rid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'd0;
            rresp_reg  <= 2'b00;
            rid_reg    <= 4'd0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rdata_next;
            rresp_reg  <= rresp_next;
            rid_reg    <= axi_arid;
        end else if (rvalid_reg && axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign axi_rvalid  = rvalid_reg;
    assign axi_arready = !rvalid_reg;
    assign axi_rdata   = rdata_reg;
    assign axi_rresp   = rresp_reg;
    assign axi_rid     = rid_reg;
    assign axi_rlast   = rvalid_reg;

endmodule

// File: tb/tb_axi4_uart_rx_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4_uart_rx_bridge
//
// Drives serial frames and AXI reads into axi4_uart_rx_bridge. A frame-level
// model (byte queue plus sticky flags) predicts every R beat and the rx_irq /
// rx_active outputs; a negedge compare process checks them every cycle, and
// the directed sequence adds literal expectations for key responses.
// ---------------------------------------------------------------------------
module tb_axi4_uart_rx_bridge;

    localparam int          CPB   = 104;
    localparam logic [31:0] BASE  = 32'h0000_0104;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        axi_arvalid = 1'b0;
    logic [31:0] axi_araddr = 32'd0;
    logic [3:0]  axi_arid = 4'd0;
    logic        axi_rready = 1'b0;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic [3:0]  axi_rid;
    logic        rx_irq;
    logic        rx_active;

    axi4_uart_rx_bridge #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .axi_arvalid(axi_arvalid),
        .axi_araddr (axi_araddr),
        .axi_arid   (axi_arid),
        .axi_arready(axi_arready),
        .axi_rvalid (axi_rvalid),
        .axi_rdata  (axi_rdata),
        .axi_rresp  (axi_rresp),
        .axi_rlast  (axi_rlast),
        .axi_rid    (axi_rid),
        .axi_rready (axi_rready),
        .rx_irq     (rx_irq),
        .rx_active  (rx_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model
    logic [7:0] model_q[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_perr = 1'b0;
    bit         model_valid = 1'b0;
    bit         exp_pending = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [1:0]  exp_rresp = 2'b00;
    logic [3:0]  exp_rid = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int sz;
        sz = model_q.size();
        s = 32'd0;
        s[0]   = (sz != 0);
        s[1]   = (sz == DEPTH);
        s[2]   = m_ovr;
        s[3]   = m_ferr;
        s[7:4] = 4'(sz);
`ifdef UART_RX_PARITY_EN
        s[8]   = m_perr;
`endif
        return s;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("rvalid", 32'(axi_rvalid), 32'(exp_pending));
            check("arready", 32'(axi_arready), 32'(!exp_pending));
            check("rlast", 32'(axi_rlast), 32'(exp_pending));
            if (exp_pending) begin
                check("rdata", axi_rdata, exp_rdata);
                check("rresp", 32'(axi_rresp), 32'(exp_rresp));
                check("rid", 32'(axi_rid), 32'(exp_rid));
            end
            if (model_valid) begin
                check("rx_irq", 32'(rx_irq), 32'(model_q.size() != 0));
                check("rx_active_idle", 32'(rx_active), 32'd0);
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        bit par_ok;
        model_valid = 1'b0;
        $display("frame data=0x%02h stop=%0d par=%0d", b, stop_bit, par_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_bit;
        tick(CPB);
        par_ok = (par_bit == ^b);
`else
        par_ok = 1'b1;
`endif
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
        if (!par_ok) m_perr = 1'b1;
        if (!stop_bit) begin
            m_ferr = 1'b1;
        end else if (par_ok) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else m_ovr = 1'b1;
        end
        model_valid = 1'b1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int hold,
                            output logic [31:0] rdata, output logic [1:0] rresp,
                            output logic [3:0] rid, output logic rlast);
        axi_araddr  = addr;
        axi_arid    = id;
        axi_arvalid = 1'b1;
        tick(1);
        axi_arvalid = 1'b0;
        // Model side effects at the address handshake
        exp_rid   = id;
        exp_rresp = 2'b00;
        if (addr == BASE) begin
            if (model_q.size() != 0) exp_rdata = {23'd0, 1'b1, model_q.pop_front()};
            else exp_rdata = 32'd0;
        end else if (addr == BASE + 32'd4) begin
            exp_rdata = model_status();
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
        end else begin
            exp_rdata = 32'd0;
            exp_rresp = 2'b10;
        end
        exp_pending = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            check("arready_hold", 32'(axi_arready), 32'd0);
        end
        rdata = axi_rdata;
        rresp = axi_rresp;
        rid   = axi_rid;
        rlast = axi_rlast;
        axi_rready = 1'b1;
        tick(1);
        axi_rready  = 1'b0;
        exp_pending = 1'b0;
        $display("read addr=0x%08h id=0x%0h rdata=0x%08h rresp=%0d", addr, id, rdata, rresp);
        tick(1);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;
    logic [3:0]  ri;
    logic        rl;

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(4);
        check("rst_arready", 32'(axi_arready), 32'd1);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        check("rst_rresp", 32'(axi_rresp), 32'd0);
        check("rst_rid", 32'(axi_rid), 32'd0);
        check("rst_rx_irq", 32'(rx_irq), 32'd0);
        check("rst_rx_active", 32'(rx_active), 32'd0);
        rst_n = 1'b1;
        tick(5);
        model_valid = 1'b1;

        // Single frame 0x55
        send_frame(8'h55, 1'b1, 1'b0);
        tick(5);
        check("irq_before_pop", 32'(rx_irq), 32'd1);
        axi_read(BASE, 4'h1, 0, rd, rr, ri, rl);
        check("rx55_rdata", rd, 32'h0000_0155);
        check("rx55_rresp", 32'(rr), 32'd0);
        check("irq_after_pop", 32'(rx_irq), 32'd0);
        axi_read(BASE, 4'h2, 0, rd, rr, ri, rl);
        check("empty_rdata", rd, 32'h0);

        // Six back-to-back frames, no reads: two overruns
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, ^8'(i));
        tick(5);
        axi_read(BASE + 32'd4, 4'h3, 0, rd, rr, ri, rl);
        check("status_full", rd, 32'h0000_0047);
        for (int i = 1; i <= 4; i++) begin
            axi_read(BASE, 4'h4, 0, rd, rr, ri, rl);
            check("drain", rd, 32'h100 + 32'(i));
        end
        axi_read(BASE + 32'd4, 4'h5, 0, rd, rr, ri, rl);
        check("status_cleared", rd, 32'h0);

        // Framing error
        send_frame(8'hA3, 1'b0, ^8'hA3);
        tick(5);
        check("ferr_irq", 32'(rx_irq), 32'd0);
        axi_read(BASE + 32'd4, 4'h6, 0, rd, rr, ri, rl);
        check("status_ferr", rd, 32'h0000_0008);

        // 30-cycle glitch
        model_valid = 1'b0;
        uart_rx = 1'b0;
        tick(20);
        check("glitch_active", 32'(rx_active), 32'd1);
        tick(10);
        uart_rx = 1'b1;
        begin
            int w;
            w = 0;
            while (rx_active && w < 60) begin
                tick(1);
                w++;
            end
        end
        check("glitch_recover", 32'(rx_active), 32'd0);
        model_valid = 1'b1;
        tick(5);
        axi_read(BASE + 32'd4, 4'h7, 0, rd, rr, ri, rl);
        check("status_glitch", rd, 32'h0);

        // Unmapped address with delayed rready
        axi_read(32'h0000_0200, 4'hA, 5, rd, rr, ri, rl);
        check("bad_rresp", 32'(rr), 32'd2);
        check("bad_rdata", rd, 32'h0);
        check("bad_rid", 32'(ri), 32'hA);
        check("bad_rlast", 32'(rl), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Parity: correct then wrong
        send_frame(8'h07, 1'b1, 1'b1);
        tick(5);
        axi_read(BASE, 4'h8, 0, rd, rr, ri, rl);
        check("par_good", rd, 32'h0000_0107);
        send_frame(8'h07, 1'b1, 1'b0);
        tick(5);
        axi_read(BASE + 32'd4, 4'h9, 0, rd, rr, ri, rl);
        check("par_bad_status", rd, 32'h0000_0100);
`endif

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
